// File: rtl/clk_div_prog_pkg.sv
// Shared definitions for the programmable clock divider.
//   CLK_DIV_W_DEF        default divisor width
//   CLK_DIV_DEFAULT_DEF  default divisor after reset
//   clog2()              ceiling log2 helper for sizing counters elsewhere
package clk_div_prog_pkg;

  localparam int unsigned CLK_DIV_W_DEF       = 8;
  localparam int unsigned CLK_DIV_DEFAULT_DEF = 5;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider core: period counter, posedge phase register, negedge retime and
// the clkout mux (even / odd / bypass).
// Ports:
//   clk, rst_n   source clock, synchronous active-low reset
//   busy         divider currently running
//   busy_nxt     running state after this posedge
//   n_act        divisor of the current period
//   n_nxt        divisor in force after this posedge
//   wrap         last source cycle of the current period
//   clkout       divided clock
module clk_div_core
  import clk_div_prog_pkg::*;
#(
  parameter int unsigned DIV_W = CLK_DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             busy,
  input  logic             busy_nxt,
  input  logic [DIV_W-1:0] n_act,
  input  logic [DIV_W-1:0] n_nxt,
  output logic             wrap,
  output logic             clkout
);

  logic [DIV_W-1:0] cnt_d, cnt_q;
  logic             clk_p_d, clk_p_q;
  logic             clk_n_d, clk_n_q;
  logic [DIV_W:0]   half_nxt;

  always_comb begin
    wrap  = busy && (cnt_q == n_act - DIV_W'(1));
    cnt_d = '0;
    if (busy && !wrap) cnt_d = cnt_q + DIV_W'(1);
    // High phase covers the first ceil(N/2) counts of the period that the
    // new count belongs to, so the divisor used is the one after this edge.
    half_nxt = ({1'b0, n_nxt} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    clk_p_d  = busy_nxt && ({1'b0, cnt_d} < half_nxt);
    // The negedge copy clears while reset is held low.
    clk_n_d  = rst_n ? clk_p_q : 1'b0;
  end

  // Stage boundary: posedge counter and phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clk_p_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clk_p_q <= clk_p_d;
    end
  end

  // Stage boundary: half-cycle retime of the phase for odd divisors.
  always_ff @(negedge clk) begin
    clk_n_q <= clk_n_d;
  end

  // Odd N: AND with the half-cycle-late copy trims the high time to N/2.
  // N=1: the source clock is gated straight through while running.
  always_comb begin
    if (n_act == DIV_W'(1))  clkout = clk_p_q & clk;
    else if (n_act[0])       clkout = clk_p_q & clk_n_q;
    else                     clkout = clk_p_q;
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with boundary-aligned divisor loads.
// Ports:
//   clk       source clock
//   rst_n     synchronous reset, active-low
//   en        run request
//   div_i     new divisor value (0 is treated as 1)
//   div_load  one-cycle strobe capturing div_i
//   clkout    divided clock
//   tick      one-clk pulse on the last source cycle of each output period
//   busy      divider running
//   pend      a loaded divisor is waiting for a period boundary
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int unsigned DIV_W       = CLK_DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load,
  output logic             clkout,
  output logic             tick,
  output logic             busy,
  output logic             pend
);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  logic             busy_d, busy_q;
  logic             pend_d, pend_q;
  logic [DIV_W-1:0] n_act_d, n_act_q;
  logic [DIV_W-1:0] n_pend_d, n_pend_q;
  logic             wrap;

  always_comb begin
    busy_d   = busy_q;
    pend_d   = pend_q;
    n_act_d  = n_act_q;
    n_pend_d = n_pend_q;
    // Period boundary: either idle or on the last cycle of a period. Run
    // state and divisor may only change here, so no partial periods.
    if (!busy_q || wrap) begin
      busy_d = en;
      if (pend_q) begin
        n_act_d = n_pend_q;
        pend_d  = 1'b0;
      end
    end
    // A load arriving on a boundary edge is not yet visible in pend_q,
    // so it waits for the following boundary.
    if (div_load) begin
      n_pend_d = clamp_div(div_i);
      pend_d   = 1'b1;
    end
  end

  // Stage boundary: run control and divisor registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      pend_q   <= 1'b0;
      n_act_q  <= DIV_W'(DEFAULT_DIV);
      n_pend_q <= DIV_W'(DEFAULT_DIV);
    end else begin
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      n_act_q  <= n_act_d;
      n_pend_q <= n_pend_d;
    end
  end

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy_q),
    .busy_nxt (busy_d),
    .n_act    (n_act_q),
    .n_nxt    (n_act_d),
    .wrap     (wrap),
    .clkout   (clkout)
  );

  assign tick = wrap;
  assign busy = busy_q;
  assign pend = pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: a period-level model checked every half cycle plus
// directed scenarios with hand-computed high-time, tick and status counts.
module tb_clk_div_prog;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, en, div_load;
  logic [DIV_W-1:0] div_i;
  logic             clkout, tick, busy, pend;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: running flag, position inside the output period, period length,
  // pending divisor.
  int m_run, m_ph, m_n, m_pend, m_np;
  bit m_valid = 1'b0;

  // Results of the last run() window.
  int r_hp, r_hn, r_tk, r_busy, r_pend;

  always #5 clk = ~clk;

  clk_div_prog #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_i    (div_i),
    .div_load (div_load),
    .clkout   (clkout),
    .tick     (tick),
    .busy     (busy),
    .pend     (pend)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Period-level update at each posedge.
  task automatic model_step();
    if (!rst_n) begin
      m_run = 0; m_ph = 0; m_n = 5; m_pend = 0; m_np = 5; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_run == 0 || m_ph == m_n - 1) begin
        if (m_pend != 0) begin
          m_n    = m_np;
          m_pend = 0;
        end
        m_run = int'(en);
        m_ph  = 0;
      end else begin
        m_ph = m_ph + 1;
      end
      if (div_load) begin
        m_np   = (div_i == '0) ? 1 : int'(div_i);
        m_pend = 1;
      end
    end
  endtask

  // Expected clkout just after a posedge (neg=0) or just after a negedge (neg=1).
  function automatic int exp_clk(input bit neg);
    int h;
    if (m_run == 0) return 0;
    if (m_n == 1) return neg ? 0 : 1;
    h = (m_n + 1) / 2;
    if (m_n % 2 == 0) return int'(m_ph < m_n / 2);
    if (neg) return int'(m_ph < h);
    return int'(m_ph >= 1 && m_ph < h);
  endfunction

  task automatic check_all(input string tag, input bit neg);
    chk({tag, "_clkout"}, int'(clkout), exp_clk(neg));
    chk({tag, "_tick"},   int'(tick),   int'(m_run != 0 && m_ph == m_n - 1));
    chk({tag, "_busy"},   int'(busy),   m_run);
    chk({tag, "_pend"},   int'(pend),   m_pend);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (m_valid) check_all("cyc_pos", 1'b0);
      @(negedge clk);
      #1;
      if (m_valid) check_all("cyc_neg", 1'b1);
    end
  end

  task automatic run(input int n);
    r_hp = 0; r_hn = 0; r_tk = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      r_hp += int'(clkout);
      @(negedge clk); #1;
      r_hn += int'(clkout);
      r_tk += int'(tick);
      r_busy = int'(busy);
      r_pend = int'(pend);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_i = '0;

    // Reset state
    run(3);
    chk("rst_clkout", r_hp + r_hn, 0);
    chk("rst_tick",   r_tk, 0);
    chk("rst_busy",   r_busy, 0);
    chk("rst_pend",   r_pend, 0);
    chk("model_rst_n", m_n, 5);

    // Default N=5: 3 high at negedge samples, 2 at posedge samples (2.5 cycles)
    rst_n = 1'b1; en = 1'b1;
    run(5);
    chk("n5_hi_neg", r_hn, 3);
    chk("n5_hi_pos", r_hp, 2);
    chk("n5_ticks",  r_tk, 1);
    chk("n5_busy",   r_busy, 1);

    // Stop, then load 4 while idle
    en = 1'b0;
    run(2);
    chk("stop_busy", r_busy, 0);
    chk("stop_clk",  r_hp + r_hn, 0);
    div_i = 8'd4; div_load = 1'b1;
    run(1);
    chk("idle_pend_set", r_pend, 1);
    div_load = 1'b0;
    run(1);
    chk("idle_pend_clr", r_pend, 0);
    chk("model_n4", m_n, 4);
    en = 1'b1;
    run(8);
    chk("n4_hi_neg", r_hn, 4);
    chk("n4_hi_pos", r_hp, 4);
    chk("n4_ticks",  r_tk, 2);

    // Running N=4, load 6 at cnt=1
    run(2);
    div_i = 8'd6; div_load = 1'b1;
    run(1);
    chk("run_pend_set", r_pend, 1);
    div_load = 1'b0;
    run(1);
    chk("run_pend_hold", r_pend, 1);
    chk("run_wrap_tick", r_tk, 1);
    run(1);
    chk("run_pend_clr", r_pend, 0);
    run(6);
    chk("n6_hi_neg", r_hn, 3);
    chk("n6_hi_pos", r_hp, 3);
    chk("n6_ticks",  r_tk, 1);

    // Drop en at cnt=1: period completes, then idle low
    run(1);
    en = 1'b0;
    run(4);
    chk("drain_hi_neg", r_hn, 1);
    chk("drain_ticks",  r_tk, 1);
    chk("drain_busy",   r_busy, 1);
    run(3);
    chk("drained_busy", r_busy, 0);
    chk("drained_clk",  r_hp + r_hn, 0);

    // en falls together with a load of 3: stop with N=3
    en = 1'b1;
    run(1);
    div_i = 8'd3; div_load = 1'b1; en = 1'b0;
    run(1);
    chk("sim_pend", r_pend, 1);
    div_load = 1'b0;
    run(5);
    chk("sim_busy", r_busy, 0);
    chk("sim_pend_clr", r_pend, 0);
    chk("model_n3", m_n, 3);
    en = 1'b1;
    run(3);
    chk("n3_hi_neg", r_hn, 2);
    chk("n3_hi_pos", r_hp, 1);
    chk("n3_ticks",  r_tk, 1);

    // Load 7 on the wrap edge, then overwrite with 0 -> bypass
    div_i = 8'd7; div_load = 1'b1;
    run(1);
    chk("wrapload_pend", r_pend, 1);
    div_i = 8'd0;
    run(1);
    div_load = 1'b0;
    run(1);
    chk("wrapload_tick", r_tk, 1);
    run(1);
    chk("byp_pend_clr", r_pend, 0);
    chk("model_n1", m_n, 1);
    run(4);
    chk("byp_hi_pos", r_hp, 4);
    chk("byp_hi_neg", r_hn, 0);
    chk("byp_ticks",  r_tk, 4);

    // Reset during bypass
    rst_n = 1'b0;
    run(2);
    chk("byprst_clk",  r_hp + r_hn, 0);
    chk("byprst_busy", r_busy, 0);
    chk("byprst_tick", r_tk, 0);

    // Reset mid-period with a pending load: load is lost
    rst_n = 1'b1; en = 1'b1;
    run(3);
    div_i = 8'd9; div_load = 1'b1;
    run(1);
    chk("midrst_pend_set", r_pend, 1);
    div_load = 1'b0; rst_n = 1'b0;
    run(1);
    chk("midrst_clk",  r_hp + r_hn, 0);
    chk("midrst_pend", r_pend, 0);
    chk("midrst_busy", r_busy, 0);
    rst_n = 1'b1;
    run(5);
    chk("post_rst_hi_neg", r_hn, 3);
    chk("post_rst_ticks",  r_tk, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
